// File: rtl/w5300_pkg.sv
// Shared types and elaboration-time helpers for the W5300 host-bus master.
// Timing parameters are given in ns/us and turned into clock ticks here.
package w5300_pkg;

  localparam int TIMER_W = 24;

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } bus_state_e;

  // Round up so a programmed time is never shortened; every phase lasts at least one tick.
  function automatic int ns2ticks(input int ns, input int mhz);
    int t;
    t = (ns * mhz + 999) / 1000;
    return (t < 1) ? 1 : t;
  endfunction

  function automatic int us2ticks(input int us, input int mhz);
    int t;
    t = us * mhz;
    return (t < 1) ? 1 : t;
  endfunction

  function automatic bit data_w_ok(input int w);
    return (w == 8) || (w == 16);
  endfunction

endpackage

// File: rtl/w5300_tick_timer.sv
// Down-counter shared by all timed bus phases: start loads a tick count and
// done_o is high on the last tick of that phase.
module w5300_tick_timer
  import w5300_pkg::*;
#(
  parameter logic [TIMER_W-1:0] RST_LOAD = TIMER_W'(1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [TIMER_W-1:0] load_i,
  output logic               done_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      cnt_d = load_i - TIMER_W'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  // Leaving reset the timer is already running the first (reset-low) phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_LOAD - TIMER_W'(1);
      run_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/w5300_bus_ctrl.sv
// W5300 direct-bus master: reset sequencing, then single/burst accesses at a fixed address.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
module w5300_bus_ctrl
  import w5300_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 10,
  parameter int LEN_W        = 8,
  parameter int SETUP_NS     = 10,
  parameter int STROBE_NS    = 65,
  parameter int HOLD_NS      = 10,
  parameter int RECOV_NS     = 30,
  parameter int RST_LOW_US   = 2,
  parameter int RST_WAIT_US  = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              init_done,
  output logic              busy,
  output logic              w_rst_n,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output bus_state_e        dbg_state
);

  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("w5300_bus_ctrl: DATA_W must be 8 or 16");
  end

  localparam logic [TIMER_W-1:0] T_SETUP    = TIMER_W'(ns2ticks(SETUP_NS, CLK_FREQ_MHZ));
  localparam logic [TIMER_W-1:0] T_STROBE   = TIMER_W'(ns2ticks(STROBE_NS, CLK_FREQ_MHZ));
  localparam logic [TIMER_W-1:0] T_HOLD     = TIMER_W'(ns2ticks(HOLD_NS, CLK_FREQ_MHZ));
  localparam logic [TIMER_W-1:0] T_RECOV    = TIMER_W'(ns2ticks(RECOV_NS, CLK_FREQ_MHZ));
  localparam logic [TIMER_W-1:0] T_RST_LOW  = TIMER_W'(us2ticks(RST_LOW_US, CLK_FREQ_MHZ));
  localparam logic [TIMER_W-1:0] T_RST_WAIT = TIMER_W'(us2ticks(RST_WAIT_US, CLK_FREQ_MHZ));

  bus_state_e         state_q, state_d;
  logic               write_q, write_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               fin_q, fin_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               swrst_q, swrst_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_last_q, rsp_last_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               tmr_start;
  logic [TIMER_W-1:0] tmr_load;
  logic               tmr_done;
  logic               bus_act;

  w5300_tick_timer #(.RST_LOAD(T_RST_LOW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (tmr_start),
    .load_i  (tmr_load),
    .done_o  (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    fin_d       = fin_q;
    wdata_d     = wdata_q;
    swrst_d     = swrst_q;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    rsp_data_d  = rsp_data_q;
    tmr_start   = 1'b0;
    tmr_load    = T_SETUP;
    // A soft reset arriving mid-burst is parked until the burst drains back to IDLE.
    if (sw_rst && (state_q != ST_RST_LOW) && (state_q != ST_RST_WAIT)) swrst_d = 1'b1;
    case (state_q)
      ST_RST_LOW: if (tmr_done) begin
        state_d   = ST_RST_WAIT;
        tmr_start = 1'b1;
        tmr_load  = T_RST_WAIT;
      end
      ST_RST_WAIT: if (tmr_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (sw_rst || swrst_q) begin
          state_d   = ST_RST_LOW;
          swrst_d   = 1'b0;
          tmr_start = 1'b1;
          tmr_load  = T_RST_LOW;
        end else if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          cnt_d   = req_len;
          fin_d   = 1'b0;
          if (req_write) begin
            state_d = ST_WDATA;
          end else begin
            state_d   = ST_SETUP;
            tmr_start = 1'b1;
          end
        end
      end
      ST_WDATA: if (wr_valid) begin
        wdata_d   = wr_data;
        state_d   = ST_SETUP;
        tmr_start = 1'b1;
      end
      ST_SETUP: if (tmr_done) begin
        state_d   = ST_STROBE;
        tmr_start = 1'b1;
        tmr_load  = T_STROBE;
      end
      ST_STROBE: if (tmr_done) begin
        state_d   = ST_HOLD;
        tmr_start = 1'b1;
        tmr_load  = T_HOLD;
        if (!write_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = data;
          rsp_last_d  = (cnt_q == '0);
        end
      end
      ST_HOLD: if (tmr_done) begin
        state_d   = ST_RECOVER;
        tmr_start = 1'b1;
        tmr_load  = T_RECOV;
        fin_d     = (cnt_q == '0);
        if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
      end
      ST_RECOVER: if (tmr_done) begin
        if (fin_q) begin
          state_d = ST_IDLE;
        end else if (write_q) begin
          state_d = ST_WDATA;
        end else begin
          state_d   = ST_SETUP;
          tmr_start = 1'b1;
        end
      end
      default: state_d = ST_RST_LOW;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST_LOW;
      write_q     <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      fin_q       <= 1'b0;
      wdata_q     <= '0;
      swrst_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      fin_q       <= fin_d;
      wdata_q     <= wdata_d;
      swrst_q     <= swrst_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Pins decode straight from the state register so an async reset idles them at once.
  assign bus_act   = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
  assign cs_n      = !bus_act;
  assign rd_n      = !((state_q == ST_STROBE) && !write_q);
  assign wr_n      = !((state_q == ST_STROBE) && write_q);
  assign w_rst_n   = (state_q != ST_RST_LOW);
  assign addr      = bus_act ? addr_q : '0;
  assign data      = (bus_act && write_q) ? wdata_q : 'z;
  assign req_ready = (state_q == ST_IDLE) && !sw_rst && !swrst_q;
  assign wr_ready  = (state_q == ST_WDATA);
  assign init_done = (state_q != ST_RST_LOW) && (state_q != ST_RST_WAIT);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rsp_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_w5300_bus_ctrl.sv
// Bench for w5300_bus_ctrl at 100 MHz: pin-level W5300 model, transaction queues,
// directed timing steps plus randomized single/burst traffic.
module tb_w5300_bus_ctrl;
  import w5300_pkg::*;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int LW = 8;
  localparam logic [DW-1:0] HIZ = {DW{1'b1}};  // undriven bus reads high through the pull-ups

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sw_rst = 1'b0;
  logic req_valid = 1'b0;
  logic req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic req_ready, wr_ready, rsp_valid, rsp_last, init_done, busy;
  logic w_rst_n, cs_n, rd_n, wr_n;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] addr;
  wire  [DW-1:0] data;
  bus_state_e dbg_state;

  logic dev_oe;
  logic [DW-1:0] dev_drv = '0;
  assign dev_oe = !cs_n && !rd_n;
  assign data = dev_oe ? dev_drv : 'z;
  for (genvar g = 0; g < DW; g++) begin : g_pu
    pullup (data[g]);
  end

  w5300_bus_ctrl dut (
    .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .init_done(init_done), .busy(busy),
    .w_rst_n(w_rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .data(data), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;
  int cs_pre_init = 0;
  logic cur_write = 1'b0;
  logic [AW-1:0] cur_addr = '0;

  logic [AW+DW-1:0] exp_wr_q[$];   // {addr, data} per write beat
  logic [DW:0]      exp_rsp_q[$];  // {last, data} per read beat
  logic [DW-1:0]    dev_q[$];      // values the W5300 model presents, in order

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pin monitor / W5300 model
  int cs_len = 0, cs_gap = 0, st_len = 0;
  bit have_rise = 1'b0;
  logic prev_cs = 1'b1, prev_rd = 1'b1, prev_wr = 1'b1, prev_st = 1'b0;
  always @(negedge clk) begin : p_mon
    logic [AW+DW-1:0] ew;
    logic [DW:0] er;
    logic st;
    st = !rd_n || !wr_n;
    if (!rst_n) begin
      cs_len = 0; st_len = 0; have_rise = 1'b0;
      prev_cs = 1'b1; prev_rd = 1'b1; prev_wr = 1'b1; prev_st = 1'b0;
    end else begin
      if (!cs_n && !init_done) cs_pre_init++;
      if (!cs_n) begin
        if (prev_cs) begin
          if (have_rise) chk("cs_gap_ge3", 32'(cs_gap >= 3), 32'd1);
          cs_len = 0;
        end
        cs_len++;
        if (cur_write) begin
          if (exp_wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
          else chk("wr_data_stable", 32'(data), 32'(exp_wr_q[0][DW-1:0]));
        end
      end else begin
        if (!prev_cs) begin
          chk("cs_low_len", cs_len, 32'd9);
          have_rise = 1'b1;
          cs_gap = 0;
        end
        cs_gap++;
      end
      if (st) begin
        if (!prev_st) st_len = 0;
        st_len++;
      end else if (prev_st) begin
        chk("strobe_len", st_len, 32'd7);
      end
      if (prev_rd && !rd_n) begin
        dev_drv = (dev_q.size() > 0) ? dev_q.pop_front() : '0;
        chk("rd_addr", 32'(addr), 32'(cur_addr));
      end
      if (!prev_wr && wr_n) begin
        if (exp_wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          ew = exp_wr_q.pop_front();
          chk("wr_addr_data", 32'({addr, data}), 32'(ew));
        end
      end
      prev_cs = cs_n; prev_rd = rd_n; prev_wr = wr_n; prev_st = st;
    end
    if (rsp_valid) begin
      if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        er = exp_rsp_q.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(er[DW-1:0]));
        chk("rsp_last", 32'(rsp_last), 32'(er[DW]));
        rsp_cnt++;
      end
    end
  end

  task automatic send_req(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n;
    cur_write = w;
    cur_addr  = a;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
    n = 0;
    while (!req_ready && n < 20000) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wr_beat(input logic [DW-1:0] d, input int stall, input bit chk_z);
    int n;
    n = 0;
    @(negedge clk);
    while (!wr_ready && n < 2000) begin @(negedge clk); n++; end
    if (!wr_ready) chk("wr_ready_timeout", 32'd0, 32'd1);
    for (int i = 0; i < stall; i++) begin
      if (chk_z) begin
        chk("stall_cs_high", 32'(cs_n), 32'd1);
        chk("stall_data_hiz", 32'(data), 32'(HIZ));
      end
      @(negedge clk);
    end
    wr_valid = 1'b1;
    wr_data  = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin @(negedge clk); n++; end
    if (busy) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // Measures the W5300 reset pulse and the wait until init_done, starting with w_rst_n low.
  task automatic measure_reset_seq(input string tag);
    int n, m;
    n = 0;
    while (!w_rst_n && n < 1000) begin n++; @(negedge clk); end
    chk({tag, "_wrst_low_clk"}, n, 32'd200);
    m = 0;
    while (!init_done && m < 10000) begin m++; @(negedge clk); end
    chk({tag, "_init_wait_clk"}, m, 32'd5000);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input int len, input int stall_max);
    logic [DW-1:0] d[$];
    for (int i = 0; i <= len; i++) begin
      d.push_back(DW'($urandom_range(0, 32'hFFFE)));
      exp_wr_q.push_back({a, d[i]});
    end
    send_req(1'b1, a, LW'(len));
    for (int i = 0; i <= len; i++) wr_beat(d[i], $urandom_range(0, stall_max), 1'b0);
    wait_idle();
  endtask

  task automatic push_read(input int len);
    logic [DW-1:0] v;
    for (int i = 0; i <= len; i++) begin
      v = DW'($urandom);
      dev_q.push_back(v);
      exp_rsp_q.push_back({(i == len), v});
    end
  endtask

  initial begin : p_watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    int n, base;
    // Reset values
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_w_rst_n", 32'(w_rst_n), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_rd_n", 32'(rd_n), 32'd1);
    chk("rst_wr_n", 32'(wr_n), 32'd1);
    chk("rst_data_hiz", 32'(data), 32'(HIZ));
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_last, rsp_data}), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Power-up sequencing
    @(negedge clk);
    chk("pwr_req_ready_pre_init", 32'(req_ready), 32'd0);
    measure_reset_seq("pwr");
    chk("pwr_req_ready_idle", 32'(req_ready), 32'd1);

    // Single write 0x208 <= 0xA55A
    exp_wr_q.push_back({10'h208, 16'hA55A});
    send_req(1'b1, 10'h208, 8'd0);
    wr_beat(16'hA55A, 0, 1'b0);
    wait_idle();

    // Read burst of 4 at 0x230 returning 1,2,3,4
    for (int i = 1; i <= 4; i++) begin
      dev_q.push_back(DW'(i));
      exp_rsp_q.push_back({(i == 4), DW'(i)});
    end
    base = rsp_cnt;
    send_req(1'b0, 10'h230, 8'd3);
    wait_idle();
    chk("rdburst_rsp_count", rsp_cnt - base, 32'd4);

    // Write burst of 2 with beat 2 stalled 20 clk
    exp_wr_q.push_back({10'h22E, 16'h1234});
    exp_wr_q.push_back({10'h22E, 16'h5678});
    send_req(1'b1, 10'h22E, 8'd1);
    wr_beat(16'h1234, 0, 1'b0);
    wr_beat(16'h5678, 20, 1'b1);
    wait_idle();

    // Randomized traffic
    for (int t = 0; t < 12; t++) begin
      int len;
      logic [AW-1:0] a;
      len = $urandom_range(0, 3);
      a = AW'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, len, 4);
      end else begin
        push_read(len);
        base = rsp_cnt;
        send_req(1'b0, a, LW'(len));
        wait_idle();
        chk("rand_rsp_count", rsp_cnt - base, len + 1);
      end
    end

    // sw_rst during read burst: burst completes, then reset sequence reruns
    push_read(3);
    base = rsp_cnt;
    send_req(1'b0, 10'h230, 8'd3);
    repeat (5) @(negedge clk);
    sw_rst = 1'b1;
    @(negedge clk);
    sw_rst = 1'b0;
    n = 0;
    while (w_rst_n && n < 2000) begin @(negedge clk); n++; end
    chk("swrst_burst_done", rsp_cnt - base, 32'd4);
    chk("swrst_init_dropped", 32'(init_done), 32'd0);
    measure_reset_seq("swrst");

    // sw_rst and req_valid together in IDLE: request loses
    @(negedge clk);
    cur_write = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h3FF; req_len = '0;
    sw_rst = 1'b1;
    #1 chk("swrst_same_cycle_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    sw_rst = 1'b0;
    req_valid = 1'b0;
    chk("swrst_idle_wrst_low", 32'(w_rst_n), 32'd0);
    chk("swrst_idle_init_dropped", 32'(init_done), 32'd0);
    measure_reset_seq("swrst_idle");
    cur_write = 1'b0;

    // rst_n asserted in STROBE
    push_read(3);
    send_req(1'b0, 10'h231, 8'd3);
    n = 0;
    @(negedge clk);
    while (rd_n && n < 200) begin @(negedge clk); n++; end
    chk("strobe_reached", 32'(rd_n), 32'd0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("arst_cs_n", 32'(cs_n), 32'd1);
    chk("arst_rd_n", 32'(rd_n), 32'd1);
    chk("arst_data_hiz", 32'(data), 32'(HIZ));
    chk("arst_w_rst_n", 32'(w_rst_n), 32'd0);
    dev_q.delete();
    exp_rsp_q.delete();
    base = rsp_cnt;
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    measure_reset_seq("arst");
    chk("arst_no_rsp_after", rsp_cnt - base, 32'd0);

    // End-of-run bookkeeping
    chk("cs_before_init", cs_pre_init, 32'd0);
    chk("wr_queue_empty", exp_wr_q.size(), 32'd0);
    chk("rsp_queue_empty", exp_rsp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
